countdown_sequencer: RTL

COUNTDOWN_SEQUENCER -- requirements
Module: countdown_sequencer

---
 rtl/countdown_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/countdown_sequencer.sv
// Control sequencer for a mm:ss countdown timer: edge-detected buttons drive an
// IDLE/SET_MIN/SET_SEC/RUN machine with a 1 s tick prescaler, auto-repeat and a blinking alarm.
module countdown_sequencer #(
    parameter int TICK_DIV    = 100000000,
    parameter int REPEAT_DLY  = 50000000,
    parameter int REPEAT_RATE = 10000000,
    parameter int ALARM_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trig,
    input  logic       set,
    input  logic       up,
    input  logic       down,
    input  logic       complete,
    output logic       init_regs,
    output logic       count_enabled,
    output logic       inc,
    output logic       dec,
    output logic       min,
    output logic [3:0] state,
    output logic       alarm
);
    localparam int HALF      = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
    localparam int ALARM_LEN = ALARM_TICKS * TICK_DIV;
    localparam int REP_MAX   = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int PW        = $clog2(TICK_DIV + 1);
    localparam int RW        = $clog2(REP_MAX + 1);
    localparam int HW        = $clog2(HALF + 1);
    localparam int AW        = $clog2(ALARM_LEN + 1);

    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] DLY_LAST   = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_LEN - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        SET_MIN = 4'b0010,
        SET_SEC = 4'b0100,
        RUN     = 4'b1000
    } state_t;

    state_t        state_q, state_nx;
    logic          trig_p1, set_p1, up_p1, down_p1, primed;
    logic          trig_ev, set_ev, up_ev, down_ev, any_ev;
    logic [PW-1:0] presc;
    logic          tick;
    logic          rep_active, rep_first, rep_up;
    logic [RW-1:0] rep_cnt;
    logic          in_set, rep_hold, rep_fire, rep_start;
    logic          alarm_active;
    logic [HW-1:0] half_cnt;
    logic [AW-1:0] alarm_cnt;
    logic          init_nx, min_nx, ce_nx, inc_nx, dec_nx, done;

    // Edge detection; the first cycle after reset only samples, so held levels give no event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            primed  <= 1'b0;
            trig_p1 <= 1'b0;
            set_p1  <= 1'b0;
            up_p1   <= 1'b0;
            down_p1 <= 1'b0;
        end else begin
            primed  <= 1'b1;
            trig_p1 <= trig;
            set_p1  <= set;
            up_p1   <= up;
            down_p1 <= down;
        end
    end

    assign trig_ev = primed & trig & ~trig_p1;
    assign set_ev  = primed & set  & ~set_p1;
    assign up_ev   = primed & up   & ~up_p1;
    assign down_ev = primed & down & ~down_p1;
    assign any_ev  = trig_ev | set_ev | up_ev | down_ev;

    assign in_set    = (state_q == SET_MIN) || (state_q == SET_SEC);
    assign tick      = (state_q == RUN) && (presc == TICK_LAST);
    assign rep_start = in_set && !trig_ev && !set_ev && (up_ev != down_ev);
    assign rep_hold  = in_set && !trig_ev && !set_ev &&
                       (rep_up ? (up && !down) : (down && !up));
    assign rep_fire  = rep_active && rep_hold &&
                       (rep_cnt == (rep_first ? DLY_LAST : RATE_LAST));

    always_comb begin
        state_nx = state_q;
        ce_nx    = 1'b0;
        inc_nx   = 1'b0;
        dec_nx   = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (set_ev) state_nx = SET_MIN;
            end
            SET_MIN, SET_SEC: begin
                if (trig_ev) begin
                    if (!complete) state_nx = RUN;
                end else if (set_ev) begin
                    state_nx = (state_q == SET_MIN) ? SET_SEC : SET_MIN;
                end else if (up_ev != down_ev) begin
                    inc_nx = up_ev;
                    dec_nx = down_ev;
                end else if (rep_fire) begin
                    inc_nx = rep_up;
                    dec_nx = ~rep_up;
                end
            end
            RUN: begin
                // Pausing returns to the field held in min, which is frozen during RUN.
                if (trig_ev) begin
                    state_nx = min ? SET_MIN : SET_SEC;
                end else if (tick) begin
                    if (complete) begin
                        state_nx = SET_MIN;
                        done     = 1'b1;
                    end else begin
                        ce_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        init_nx = (state_nx == IDLE);
        if (state_nx == SET_MIN)      min_nx = 1'b1;
        else if (state_nx == SET_SEC) min_nx = 1'b0;
        else                          min_nx = min;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            init_regs     <= 1'b1;
            min           <= 1'b0;
            count_enabled <= 1'b0;
            inc           <= 1'b0;
            dec           <= 1'b0;
        end else begin
            state_q       <= state_nx;
            init_regs     <= init_nx;
            min           <= min_nx;
            count_enabled <= ce_nx;
            inc           <= inc_nx;
            dec           <= dec_nx;
        end
    end

    assign state = state_q;

    // Prescaler sits at zero outside RUN, so every RUN entry starts a full tick period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                presc <= '0;
        else if (state_q != RUN)   presc <= '0;
        else if (tick)             presc <= '0;
        else                       presc <= presc + PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_active <= 1'b0;
            rep_first  <= 1'b0;
            rep_up     <= 1'b0;
            rep_cnt    <= '0;
        end else if (rep_start) begin
            rep_active <= 1'b1;
            rep_first  <= 1'b1;
            rep_up     <= up_ev;
            rep_cnt    <= '0;
        end else if (rep_active) begin
            if (!rep_hold) begin
                rep_active <= 1'b0;
            end else if (rep_fire) begin
                rep_first <= 1'b0;
                rep_cnt   <= '0;
            end else begin
                rep_cnt <= rep_cnt + RW'(1);
            end
        end
    end

    // Completion outranks a same-cycle button edge; otherwise any edge silences the alarm.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_active <= 1'b0;
            alarm        <= 1'b0;
            half_cnt     <= '0;
            alarm_cnt    <= '0;
        end else if (done) begin
            alarm_active <= 1'b1;
            alarm        <= 1'b1;
            half_cnt     <= '0;
            alarm_cnt    <= '0;
        end else if (any_ev) begin
            alarm_active <= 1'b0;
            alarm        <= 1'b0;
        end else if (alarm_active) begin
            if (alarm_cnt == ALARM_LAST) begin
                alarm_active <= 1'b0;
                alarm        <= 1'b0;
            end else begin
                alarm_cnt <= alarm_cnt + AW'(1);
                if (half_cnt == HALF_LAST) begin
                    half_cnt <= '0;
                    alarm    <= ~alarm;
                end else begin
                    half_cnt <= half_cnt + HW'(1);
                end
            end
        end
    end
endmodule
